// File: rtl/ins_burst_server.sv
// ins_burst_server
//   Answers instruction-fetch burst requests from the instruction cache.
//   The words come from a synchronous-read program memory, which has a
//   one-cycle read latency.
//   A request is accepted in IDLE. The block then issues one memory read per
//   cycle in ISSUE. Each read comes back one cycle later as a valid beat,
//   tagged with its beat index. After the last beat, rd_burst_finish pulses
//   once.
//
// Ports
//   clk, rst              clock; asynchronous active-low reset
//   ins_read_req          level request, held until the burst is consumed
//   ins_read_addr/len     start word address and length, sampled on acceptance
//   ins_to_cache          burst data word (0 when not valid)
//   rd_cnt_isa            beat index of the current word
//   rd_burst_data_valid   ins_to_cache / rd_cnt_isa valid
//   rd_burst_finish       one-cycle completion pulse
//   busy                  high whenever the FSM is not idle
//   mem_rd_en/addr/data   program-memory read port
module ins_burst_server #(
   parameter int ISA_DEPTH       = 128,
   parameter int TOTAL_ISA_DEPTH = 128,
   parameter int DDR_ADDR_WIDTH  = 28,
   parameter int MEM_ADDR_WIDTH  = 16,
   parameter int ISA_WIDTH       = 30
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      ins_read_req,
   input  logic [DDR_ADDR_WIDTH-1:0] ins_read_addr,
   input  logic [9:0]                ins_read_len,
   output logic [ISA_WIDTH-1:0]      ins_to_cache,
   output logic [9:0]                rd_cnt_isa,
   output logic                      rd_burst_data_valid,
   output logic                      rd_burst_finish,
   output logic                      busy,
   output logic                      mem_rd_en,
   output logic [MEM_ADDR_WIDTH-1:0] mem_rd_addr,
   input  logic [ISA_WIDTH-1:0]      mem_rd_data
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;

   state_t                    state;
   logic [9:0]                len_q;
   logic [9:0]                issue_cnt;
   logic                      last_pending;

   logic [9:0]                len_clamped;
   logic [MEM_ADDR_WIDTH-1:0] start_addr;
   logic [MEM_ADDR_WIDTH-1:0] next_addr;
   logic                      abort;

   always_comb begin
      len_clamped = (ins_read_len > 10'(ISA_DEPTH)) ? 10'(ISA_DEPTH) : ins_read_len;
      start_addr  = MEM_ADDR_WIDTH'(ins_read_addr % DDR_ADDR_WIDTH'(TOTAL_ISA_DEPTH));
      // The running address steps by one and wraps, so only the start address needs a modulo.
      next_addr   = (mem_rd_addr == MEM_ADDR_WIDTH'(TOTAL_ISA_DEPTH - 1)) ?
                    '0 : mem_rd_addr + MEM_ADDR_WIDTH'(1);
      abort       = (state == S_ISSUE) && !ins_read_req;
   end

   assign ins_to_cache = rd_burst_data_valid ? mem_rd_data : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state               <= S_IDLE;
         len_q               <= '0;
         issue_cnt           <= '0;
         last_pending        <= 1'b0;
         rd_cnt_isa          <= '0;
         rd_burst_data_valid <= 1'b0;
         rd_burst_finish     <= 1'b0;
         busy                <= 1'b0;
         mem_rd_en           <= 1'b0;
         mem_rd_addr         <= '0;
      end else begin
         // Return path trails the issue path by one cycle.
         // On an abort, the read issued in this cycle is dropped.
         rd_burst_data_valid <= mem_rd_en && !abort;
         if (mem_rd_en && !abort)
            rd_cnt_isa <= issue_cnt;

         // The finish pulse and the count holding len come one cycle after the last beat.
         rd_burst_finish <= 1'b0;
         if (last_pending) begin
            rd_burst_finish <= 1'b1;
            rd_cnt_isa      <= len_q;
            last_pending    <= 1'b0;
         end

         unique case (state)
            S_IDLE: begin
               if (ins_read_req) begin
                  mem_rd_addr <= start_addr;
                  len_q       <= len_clamped;
                  issue_cnt   <= '0;
                  rd_cnt_isa  <= '0;
                  busy        <= 1'b1;
                  if (len_clamped == '0) begin
                     state           <= S_DONE;
                     rd_burst_finish <= 1'b1;
                  end else begin
                     state     <= S_ISSUE;
                     mem_rd_en <= 1'b1;
                  end
               end
            end
            S_ISSUE: begin
               if (!ins_read_req) begin
                  state     <= S_IDLE;
                  mem_rd_en <= 1'b0;
                  busy      <= 1'b0;
               end else if (issue_cnt == len_q - 10'd1) begin
                  state        <= S_DONE;
                  mem_rd_en    <= 1'b0;
                  last_pending <= 1'b1;
               end else begin
                  issue_cnt   <= issue_cnt + 10'd1;
                  mem_rd_addr <= next_addr;
               end
            end
            S_DONE: begin
               // A request that stays high is not served again.
               // The request must drop before a new burst can start.
               if (!ins_read_req) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state     <= S_IDLE;
               mem_rd_en <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ins_burst_server.sv
// tb_ins_burst_server
//   Directed bench for ins_burst_server.
//   Each stimulus step pushes the beats and finish pulse it expects into a
//   queue. A monitor on the falling edge pops one entry for every output
//   event and compares it.
module tb_ins_burst_server;

   logic        clk = 1'b0;
   logic        rst;
   logic        ins_read_req;
   logic [27:0] ins_read_addr;
   logic [9:0]  ins_read_len;
   logic [29:0] ins_to_cache;
   logic [9:0]  rd_cnt_isa;
   logic        rd_burst_data_valid;
   logic        rd_burst_finish;
   logic        busy;
   logic        mem_rd_en;
   logic [15:0] mem_rd_addr;
   logic [29:0] mem_rd_data;

   logic [29:0] mem [0:127];

   typedef struct {
      bit          fin;
      logic [29:0] data;
      logic [9:0]  cnt;
      bit          follow;
   } item_t;

   item_t exp_q[$];
   int    checks = 0;
   int    passed = 0;
   bit    prev_out = 1'b0;

   ins_burst_server #(
      .ISA_DEPTH(128),
      .TOTAL_ISA_DEPTH(128),
      .DDR_ADDR_WIDTH(28),
      .MEM_ADDR_WIDTH(16),
      .ISA_WIDTH(30)
   ) dut (
      .clk(clk),
      .rst(rst),
      .ins_read_req(ins_read_req),
      .ins_read_addr(ins_read_addr),
      .ins_read_len(ins_read_len),
      .ins_to_cache(ins_to_cache),
      .rd_cnt_isa(rd_cnt_isa),
      .rd_burst_data_valid(rd_burst_data_valid),
      .rd_burst_finish(rd_burst_finish),
      .busy(busy),
      .mem_rd_en(mem_rd_en),
      .mem_rd_addr(mem_rd_addr),
      .mem_rd_data(mem_rd_data)
   );

   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = 30'(32'h100 + i);
      mem_rd_data = '0;
   end

   always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr[6:0]];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops one expected entry for every valid beat or finish pulse.
   always @(negedge clk) begin
      item_t it;
      if (!rst) begin
         prev_out = 1'b0;
      end else begin
         if (rd_burst_data_valid || rd_burst_finish) begin
            if (exp_q.size() == 0) begin
               chk("spurious_output", {30'd0, rd_burst_data_valid, rd_burst_finish}, 32'd0);
            end else begin
               it = exp_q.pop_front();
               chk("event_kind", {30'd0, rd_burst_data_valid, rd_burst_finish},
                   it.fin ? 32'd1 : 32'd2);
               if (!it.fin) begin
                  chk("beat_data", 32'(ins_to_cache), 32'(it.data));
                  chk("beat_cnt", 32'(rd_cnt_isa), 32'(it.cnt));
               end
               if (it.follow) chk("contiguous", 32'(prev_out), 32'd1);
            end
         end
         prev_out = rd_burst_data_valid || rd_burst_finish;
      end
   end

   // Pushes the expected beats, raises the request, and returns one cycle
   // after the accepting edge. The address and length then change to junk,
   // which must have no effect on the burst.
   task automatic start_burst(input logic [27:0] addr, input logic [9:0] len,
                              input int nexp, input bit fin);
      item_t it;
      int    base;
      base = int'(addr % 28'd128);
      for (int k = 0; k < nexp; k++) begin
         it.fin    = 1'b0;
         it.data   = 30'(32'h100 + ((base + k) % 128));
         it.cnt    = 10'(k);
         it.follow = (k > 0);
         exp_q.push_back(it);
      end
      if (fin) begin
         it.fin    = 1'b1;
         it.data   = '0;
         it.cnt    = '0;
         it.follow = (nexp > 0);
         exp_q.push_back(it);
      end
      ins_read_addr = addr;
      ins_read_len  = len;
      ins_read_req  = 1'b1;
      tick();
      ins_read_addr = 28'hFFFFFFF;
      ins_read_len  = 10'd1;
      chk("busy_after_accept", 32'(busy), 32'd1);
      chk("rd_en_after_accept", 32'(mem_rd_en), (len != 0) ? 32'd1 : 32'd0);
   endtask

   task automatic wait_finish;
      bit found;
      found = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (rd_burst_finish) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      chk("finish_seen", 32'(found), 32'd1);
   endtask

   task automatic end_burst;
      ins_read_req = 1'b0;
      tick();
      chk("idle_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      rst = 1'b0;
      ins_read_req = 1'b0;
      ins_read_addr = '0;
      ins_read_len = '0;
      repeat (3) tick();
      chk("reset_outputs", {busy, mem_rd_en, rd_burst_data_valid, rd_burst_finish,
                            28'(rd_cnt_isa)}, 32'd0);
      chk("reset_addr", 32'(mem_rd_addr), 32'd0);
      rst = 1'b1;
      tick();

      // Basic burst: addr 5, len 4.
      start_burst(28'd5, 10'd4, 4, 1'b1);
      chk("addr0", 32'(mem_rd_addr), 32'd5);
      tick(); chk("addr1", 32'(mem_rd_addr), 32'd6);
      tick(); chk("addr2", 32'(mem_rd_addr), 32'd7);
      tick(); chk("addr3", 32'(mem_rd_addr), 32'd8);
      chk("rd_en_last", 32'(mem_rd_en), 32'd1);
      tick(); chk("rd_en_drop", 32'(mem_rd_en), 32'd0);
      tick(); chk("finish_pulse", 32'(rd_burst_finish), 32'd1);
      chk("cnt_holds_len", 32'(rd_cnt_isa), 32'd4);
      tick(); chk("finish_one_cycle", 32'(rd_burst_finish), 32'd0);
      chk("busy_in_done", 32'(busy), 32'd1);
      end_burst();
      chk("cnt_held_idle", 32'(rd_cnt_isa), 32'd4);

      // Wrap: 126, 127, 0, 1.
      start_burst(28'd126, 10'd4, 4, 1'b1);
      chk("wrap_a0", 32'(mem_rd_addr), 32'd126);
      tick(); chk("wrap_a1", 32'(mem_rd_addr), 32'd127);
      tick(); chk("wrap_a2", 32'(mem_rd_addr), 32'd0);
      tick(); chk("wrap_a3", 32'(mem_rd_addr), 32'd1);
      wait_finish();
      end_burst();

      // Clamp: 300 words requested, 128 returned.
      start_burst(28'd0, 10'd300, 128, 1'b1);
      wait_finish();
      chk("clamp_cnt_hold", 32'(rd_cnt_isa), 32'd128);
      end_burst();

      // Zero length: no reads, finish in the first DONE cycle.
      start_burst(28'd10, 10'd0, 0, 1'b1);
      chk("len0_finish", 32'(rd_burst_finish), 32'd1);
      chk("len0_cnt", 32'(rd_cnt_isa), 32'd0);
      tick();
      chk("len0_finish_drop", 32'(rd_burst_finish), 32'd0);
      end_burst();

      // Held request: the upper address bits are discarded by the modulo.
      // After finish the request stays high, and no second burst is served.
      start_burst(28'h0000185, 10'd3, 3, 1'b1);
      wait_finish();
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("held_no_rd_en", 32'(mem_rd_en), 32'd0);
         chk("held_busy", 32'(busy), 32'd1);
      end
      ins_read_req = 1'b0;
      tick();
      start_burst(28'd50, 10'd2, 2, 1'b1);
      chk("rearm_no_valid_yet", 32'(rd_burst_data_valid), 32'd0);
      tick();
      chk("rearm_first_beat", 32'(rd_burst_data_valid), 32'd1);
      wait_finish();
      end_burst();

      // Abort after beat 1 of an 8-word burst.
      start_burst(28'd20, 10'd8, 2, 1'b0);
      tick();
      tick();
      ins_read_req = 1'b0;
      tick();
      chk("abort_valid", 32'(rd_burst_data_valid), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_rd_en", 32'(mem_rd_en), 32'd0);
      repeat (5) tick();
      start_burst(28'd60, 10'd3, 3, 1'b1);
      wait_finish();
      end_burst();

      // Asynchronous reset while beat 3 of 8 is on the outputs.
      start_burst(28'd40, 10'd8, 4, 1'b0);
      repeat (4) tick();
      @(negedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("async_rst_ctl", {busy, mem_rd_en, rd_burst_data_valid, rd_burst_finish,
                            28'(rd_cnt_isa)}, 32'd0);
      chk("async_rst_addr", 32'(mem_rd_addr), 32'd0);
      chk("async_rst_data", 32'(ins_to_cache), 32'd0);
      ins_read_req = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      chk("post_rst_idle", {29'd0, busy, mem_rd_en, rd_burst_data_valid}, 32'd0);

      repeat (3) tick();
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/ins_burst_server.md
Name: ins_burst_server

Overview:
- Read-side responder for the instruction-fetch burst interface driven by the instruction cache (ins_read_req / ins_read_addr / ins_read_len).
- Serves each request from a synchronous-read program memory (on-chip ISA BRAM, 1-cycle read latency).
- Streams the words back as a contiguous burst with a beat counter and a valid strobe.
- Sits between the instruction cache and the program-store memory, in place of the DDR read path during ISA fetch.

Parameters:
- ISA_DEPTH, 128, maximum burst length in words; longer requests are clamped.
- TOTAL_ISA_DEPTH, 128, number of words in program memory; the address wrap modulus.
- DDR_ADDR_WIDTH, 28, width of the request address.
- MEM_ADDR_WIDTH, 16, width of the program-memory address.
- ISA_WIDTH, 30, instruction word width.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  asynchronous, active-low reset.
- ins_read_req  in  1  burst request (level); the requester holds it high until it has consumed the burst.
- ins_read_addr  in  DDR_ADDR_WIDTH  start word address; sampled on request acceptance.
- ins_read_len  in  10  burst length in words; sampled on request acceptance.
- ins_to_cache  out  ISA_WIDTH  burst data word.
- rd_cnt_isa  out  10  beat index of the current word.
- rd_burst_data_valid  out  1  ins_to_cache / rd_cnt_isa valid this cycle.
- rd_burst_finish  out  1  one-cycle pulse when the burst has completed.
- busy  out  1  high in every state except IDLE.
- mem_rd_en  out  1  program-memory read enable.
- mem_rd_addr  out  MEM_ADDR_WIDTH  program-memory read address.
- mem_rd_data  in  ISA_WIDTH  program-memory data, valid the cycle after mem_rd_en.

Behaviour:
- Reset (async, rst=0):
  - All outputs 0; state IDLE.
  - Internal start address, length and issue counter cleared.
  - Reset mid-burst aborts immediately; no finish pulse.
- States: IDLE, ISSUE, DONE.
- IDLE:
  - On a rising edge with ins_read_req=1, latch base = ins_read_addr mod TOTAL_ISA_DEPTH.
  - Latch len = min(ins_read_len, ISA_DEPTH); clear the issue counter.
  - If len=0, go to DONE; otherwise go to ISSUE.
- ISSUE (one read issued per cycle, no bubbles):
  - mem_rd_en=1; mem_rd_addr = (base + issue_cnt) mod TOTAL_ISA_DEPTH, zero-extended to MEM_ADDR_WIDTH.
  - Wrap: after address TOTAL_ISA_DEPTH-1, the next address is 0.
  - When issue_cnt reaches len-1, go to DONE.
- Data path:
  - A registered copy of mem_rd_en and issue_cnt, delayed one cycle, produces rd_burst_data_valid and rd_cnt_isa.
  - ins_to_cache = mem_rd_data, driven combinationally while valid and 0 otherwise.
- Latency:
  - Request sampled at edge E0; first mem_rd_en in the cycle after E0; first valid beat (rd_cnt_isa=0) one cycle later.
  - Beat k is valid k cycles after beat 0.
  - The last beat (rd_cnt_isa=len-1) is followed in the next cycle by rd_burst_finish=1 for exactly one cycle.
- rd_cnt_isa:
  - Equals the beat index during valid beats.
  - Holds len after the last beat until the next acceptance.
  - Reads 0 during a len=0 burst.
- len=0 request: no mem_rd_en and no valid beats; rd_burst_finish pulses in the first DONE cycle.
- DONE:
  - Remains in DONE while ins_read_req=1; a held request is never re-served.
  - Returns to IDLE on the first edge with ins_read_req=0.
  - A new burst requires the request to go low, then high.
- Abort: ins_read_req=0 sampled in ISSUE goes to IDLE.
  - mem_rd_en drops from the next cycle.
  - The one in-flight beat is suppressed: rd_burst_data_valid=0.
  - No rd_burst_finish.
- ins_read_addr / ins_read_len changes after acceptance have no effect on the current burst.
- Clamp: ins_read_len > ISA_DEPTH returns exactly ISA_DEPTH beats.

Test Plan:
- Memory[i]=i+0x100; req addr=5, len=4 -> mem_rd_addr 5,6,7,8 on consecutive cycles; beats 0..3 carry 0x105..0x108; valid for 4 contiguous cycles; finish pulses 1 cycle after beat 3; rd_cnt_isa holds 4.
- Wrap: addr=126, len=4 with TOTAL_ISA_DEPTH=128 -> addresses 126,127,0,1; data 0x17E,0x17F,0x100,0x101.
- Clamp and zero length: len=300 -> exactly 128 beats, last rd_cnt_isa=127; len=0 -> no mem_rd_en, no valid, single finish pulse.
- Held request: keep req high 10 cycles after finish -> no second burst; drop req for 1 cycle then raise it -> a new burst starts with its first beat 2 cycles after the rising sample.
- Abort: deassert req after beat 1 of a len=8 burst -> at most beats 0..1 (plus none afterward) valid; no finish; busy=0 within 1 cycle; the next request is served normally.
- Async reset asserted mid-burst (beat 3 of 8) -> all outputs 0 immediately; after release with req low, IDLE and busy=0.
